// File: rtl/display_mode_scheduler_if.sv
// -----------------------------------------------------------------------------
// display_mode_scheduler_if
// Bundles the pixel stream, the mode-request handshake and the scheduler
// outputs that sit between the game FSM, the VGA timing generator and the
// RGB selector.
//   master : the side that drives pixel timing and mode requests
//   slave  : the display_mode_scheduler itself
// Signals:
//   DE, x_pixel[9:0], y_pixel[9:0]  pixel timing from the VGA generator
//   req_valid, req_mode[1:0]        mode request from the game FSM
//   req_ready                       scheduler can accept a request
//   ui_en                           UI-priority enable to the RGB selector
//   active_mode[1:0]                mode currently on screen
//   frames_left[7:0]                countdown frames remaining
//   countdown_done                  one-cycle pulse on natural expiry
// -----------------------------------------------------------------------------
interface display_mode_scheduler_if;
    logic       DE;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic       req_valid;
    logic [1:0] req_mode;
    logic       req_ready;
    logic       ui_en;
    logic [1:0] active_mode;
    logic [7:0] frames_left;
    logic       countdown_done;

    modport master (
        output DE, x_pixel, y_pixel, req_valid, req_mode,
        input  req_ready, ui_en, active_mode, frames_left, countdown_done
    );

    modport slave (
        input  DE, x_pixel, y_pixel, req_valid, req_mode,
        output req_ready, ui_en, active_mode, frames_left, countdown_done
    );
endinterface

// File: rtl/display_mode_scheduler.sv
// -----------------------------------------------------------------------------
// display_mode_scheduler
// Frame-synchronous display-mode controller. A mode request is accepted via a
// valid/ready handshake, parked in a single pending slot and applied only at
// the last active pixel of the frame, so the picture never changes mid-frame.
// Also generates the per-pixel UI-priority enable and runs a frame-counted
// countdown overlay that falls back to live view on its own.
// Ports:
//   clk     pixel clock
//   reset   asynchronous, active-high reset
//   io_bus  display_mode_scheduler_if.slave (pixel timing, request handshake,
//           ui_en / active_mode / frames_left / countdown_done outputs)
// Modes: 0 LIVE, 1 FULL (whole screen UI), 2 BANNER (top lines), 3 COUNT
// (centred countdown box).
// -----------------------------------------------------------------------------
module display_mode_scheduler #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned BANNER_H   = 48,
    parameter int unsigned CNT_FRAMES = 180,
    parameter int unsigned BOX_X0     = 240,
    parameter int unsigned BOX_X1     = 400,
    parameter int unsigned BOX_Y0     = 176,
    parameter int unsigned BOX_Y1     = 304
) (
    input  logic                      clk,
    input  logic                      reset,
    display_mode_scheduler_if.slave   io_bus
);

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'd0,
        MODE_FULL   = 2'd1,
        MODE_BANNER = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    localparam logic [9:0] LP_X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0] LP_Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] LP_BANNER_H = 10'(BANNER_H);
    localparam logic [9:0] LP_BOX_X0   = 10'(BOX_X0);
    localparam logic [9:0] LP_BOX_X1   = 10'(BOX_X1);
    localparam logic [9:0] LP_BOX_Y0   = 10'(BOX_Y0);
    localparam logic [9:0] LP_BOX_Y1   = 10'(BOX_Y1);
    localparam logic [7:0] LP_CNT      = 8'(CNT_FRAMES);

    mode_t      r_active_mode;
    mode_t      r_pend_mode;
    logic       r_pend_valid;
    logic [7:0] r_frames_left;
    logic       r_countdown_done;

    logic       w_frame_end;
    logic       w_handshake;
    logic       w_ui_en;

    // Last active pixel of the frame: the only point where the mode may change.
    assign w_frame_end = io_bus.DE && (io_bus.x_pixel == LP_X_LAST)
                                   && (io_bus.y_pixel == LP_Y_LAST);

    // Single pending slot, no overwrite: ready only while the slot is empty.
    assign w_handshake = io_bus.req_valid && !r_pend_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active_mode    <= MODE_LIVE;
            r_pend_mode      <= MODE_LIVE;
            r_pend_valid     <= 1'b0;
            r_frames_left    <= 8'd0;
            r_countdown_done <= 1'b0;
        end else begin
            r_countdown_done <= 1'b0;

            if (w_frame_end) begin
                if (r_pend_valid) begin
                    // A pending request wins over a running countdown and
                    // silently cancels it; COUNT->COUNT restarts the count.
                    r_active_mode <= r_pend_mode;
                    r_pend_valid  <= 1'b0;
                    r_frames_left <= (r_pend_mode == MODE_COUNT) ? LP_CNT : 8'd0;
                end else if (r_active_mode == MODE_COUNT) begin
                    if (r_frames_left > 8'd1) begin
                        r_frames_left <= r_frames_left - 8'd1;
                    end else begin
                        r_active_mode    <= MODE_LIVE;
                        r_frames_left    <= 8'd0;
                        r_countdown_done <= 1'b1;
                    end
                end
            end

            // The handshake can only happen with the slot empty, so it never
            // collides with the clear above. A request accepted on the
            // frame_end cycle waits for the following frame_end.
            if (w_handshake) begin
                r_pend_valid <= 1'b1;
                r_pend_mode  <= mode_t'(io_bus.req_mode);
            end
        end
    end

    // Zero-latency UI window decode from the registered mode and live pixel.
    always_comb begin
        w_ui_en = 1'b0;
        case (r_active_mode)
            MODE_LIVE:   w_ui_en = 1'b0;
            MODE_FULL:   w_ui_en = io_bus.DE;
            MODE_BANNER: w_ui_en = io_bus.DE && (io_bus.y_pixel < LP_BANNER_H);
            MODE_COUNT:  w_ui_en = io_bus.DE
                                 && (io_bus.x_pixel >= LP_BOX_X0) && (io_bus.x_pixel < LP_BOX_X1)
                                 && (io_bus.y_pixel >= LP_BOX_Y0) && (io_bus.y_pixel < LP_BOX_Y1);
            default:     w_ui_en = 1'b0;
        endcase
    end

    assign io_bus.req_ready      = !r_pend_valid;
    assign io_bus.ui_en          = w_ui_en;
    assign io_bus.active_mode    = r_active_mode;
    assign io_bus.frames_left    = r_frames_left;
    assign io_bus.countdown_done = r_countdown_done;

endmodule

// File: tb/tb_display_mode_scheduler.sv
module tb_display_mode_scheduler;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    display_mode_scheduler_if bus ();

    display_mode_scheduler #(
        .CNT_FRAMES (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       de;
        int         x;
        int         y;
        logic       exp_ui;
    } vec_t;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[20];
    int   n_vecs;
    sb_t  sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    // Count countdown_done pulses mid-cycle, away from the active edge.
    always @(negedge clk) if (bus.countdown_done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic de, input int x, input int y);
        bus.DE      = de;
        bus.x_pixel = 10'(x);
        bus.y_pixel = 10'(y);
    endtask

    task automatic sb_push(input string tag, input int exp);
        sb_t e;
        e.tag = tag;
        e.exp = 32'(exp);
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, act, e.exp);
        end
    endtask

    // Drive one frame_end pixel, then park in horizontal blanking.
    task automatic frame_end();
        px(1'b1, 639, 479);
        tick();
        px(1'b0, 640, 479);
        $display("txn frame_end -> mode=%0d frames_left=%0d", bus.active_mode, bus.frames_left);
    endtask

    task automatic request(input int m);
        int waited = 0;
        bus.req_valid = 1'b1;
        bus.req_mode  = 2'(m);
        #1;
        while (bus.req_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) check("req_ready_timeout", 32'(waited), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        sb_push("mode_after_frame_end", m);
        $display("txn request mode=%0d accepted", m);
    endtask

    task automatic switch_mode(input int m);
        request(m);
        frame_end();
        #1;
        sb_pop_check(32'(bus.active_mode));
        check("frames_left_on_entry", 32'(bus.frames_left), (m == 3) ? 32'd3 : 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [1:0] cur;
        int d0;

        n_vecs = 0;
        // FULL
        vecs[n_vecs++] = '{2'd1, 1'b1,   0,   0, 1'b1};
        vecs[n_vecs++] = '{2'd1, 1'b1, 320, 240, 1'b1};
        vecs[n_vecs++] = '{2'd1, 1'b0, 320, 240, 1'b0};
        // LIVE
        vecs[n_vecs++] = '{2'd0, 1'b1, 300, 200, 1'b0};
        vecs[n_vecs++] = '{2'd0, 1'b1,   0,   0, 1'b0};
        // BANNER
        vecs[n_vecs++] = '{2'd2, 1'b1,   0,  47, 1'b1};
        vecs[n_vecs++] = '{2'd2, 1'b1,   0,  48, 1'b0};
        vecs[n_vecs++] = '{2'd2, 1'b0,   0,  10, 1'b0};
        vecs[n_vecs++] = '{2'd2, 1'b1, 639,   0, 1'b1};
        // COUNT
        vecs[n_vecs++] = '{2'd3, 1'b1, 240, 176, 1'b1};
        vecs[n_vecs++] = '{2'd3, 1'b1, 399, 303, 1'b1};
        vecs[n_vecs++] = '{2'd3, 1'b1, 400, 176, 1'b0};
        vecs[n_vecs++] = '{2'd3, 1'b1, 239, 200, 1'b0};
        vecs[n_vecs++] = '{2'd3, 1'b1, 300, 175, 1'b0};
        vecs[n_vecs++] = '{2'd3, 1'b1, 300, 304, 1'b0};
        vecs[n_vecs++] = '{2'd3, 1'b0, 300, 200, 1'b0};

        bus.req_valid = 1'b0;
        bus.req_mode  = 2'd0;
        px(1'b0, 0, 0);

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("rst_active_mode", 32'(bus.active_mode), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_frames_left", 32'(bus.frames_left), 32'd0);
        check("rst_ui_en", 32'(bus.ui_en), 32'd0);
        check("rst_countdown_done", 32'(bus.countdown_done), 32'd0);

        // ---- frame-aligned switch to FULL ----
        px(1'b1, 100, 200);
        bus.req_valid = 1'b1;
        bus.req_mode  = 2'd1;
        #1;
        check("ready_before_hs", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        sb_push("full_after_frame_end", 1);
        $display("txn request mode=1 accepted at (100,200)");
        check("ready_after_hs", 32'(bus.req_ready), 32'd0);
        check("mode_held_after_hs", 32'(bus.active_mode), 32'd0);
        px(1'b1, 639, 478);
        #1;
        check("mode_held_639_478", 32'(bus.active_mode), 32'd0);
        px(1'b1, 639, 479);
        #1;
        check("mode_held_at_frame_end", 32'(bus.active_mode), 32'd0);
        check("ready_low_at_frame_end", 32'(bus.req_ready), 32'd0);
        tick();
        px(1'b0, 640, 479);
        #1;
        sb_pop_check(32'(bus.active_mode));
        check("ready_after_frame_end", 32'(bus.req_ready), 32'd1);
        check("full_ui_blank", 32'(bus.ui_en), 32'd0);
        cur = 2'd1;

        // ---- table-driven ui_en windows ----
        for (int i = 0; i < n_vecs; i++) begin
            if (vecs[i].mode != cur) begin
                switch_mode(int'(vecs[i].mode));
                cur = vecs[i].mode;
            end
            px(vecs[i].de, vecs[i].x, vecs[i].y);
            sb_push($sformatf("ui_en_m%0d_de%0d_%0d_%0d", vecs[i].mode, vecs[i].de, vecs[i].x, vecs[i].y),
                    int'(vecs[i].exp_ui));
            #1;
            sb_pop_check(32'(bus.ui_en));
            $display("txn vec %0d mode=%0d de=%0d (%0d,%0d) ui_en=%0d",
                     i, vecs[i].mode, vecs[i].de, vecs[i].x, vecs[i].y, bus.ui_en);
            tick();
        end

        // ---- override of a running countdown ----
        frame_end();
        #1;
        check("count_frames_2", 32'(bus.frames_left), 32'd2);
        check("count_mode_still", 32'(bus.active_mode), 32'd3);
        d0 = done_cnt;
        request(2);
        frame_end();
        #1;
        sb_pop_check(32'(bus.active_mode));
        check("override_frames_left", 32'(bus.frames_left), 32'd0);
        repeat (3) tick();
        check("override_no_done", 32'(done_cnt), 32'(d0));

        // ---- natural countdown expiry ----
        switch_mode(3);
        frame_end();
        #1;
        check("expiry_frames_2", 32'(bus.frames_left), 32'd2);
        frame_end();
        #1;
        check("expiry_frames_1", 32'(bus.frames_left), 32'd1);
        check("expiry_mode_count", 32'(bus.active_mode), 32'd3);
        d0 = done_cnt;
        frame_end();
        #1;
        check("expiry_mode_live", 32'(bus.active_mode), 32'd0);
        check("expiry_frames_0", 32'(bus.frames_left), 32'd0);
        check("expiry_done_high", 32'(bus.countdown_done), 32'd1);
        tick();
        check("expiry_done_low", 32'(bus.countdown_done), 32'd0);
        tick();
        check("expiry_done_once", 32'(done_cnt), 32'(d0 + 1));

        // ---- handshake on the frame_end cycle, and stall while pending ----
        switch_mode(2);
        px(1'b1, 639, 479);
        bus.req_valid = 1'b1;
        bus.req_mode  = 2'd1;
        #1;
        check("simul_ready", 32'(bus.req_ready), 32'd1);
        tick();
        sb_push("simul_applied_next_frame", 1);
        $display("txn request mode=1 accepted on frame_end cycle");
        bus.req_mode = 2'd3;
        px(1'b1, 10, 10);
        #1;
        check("simul_not_applied", 32'(bus.active_mode), 32'd2);
        check("simul_ready_low", 32'(bus.req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("second_req_held_off", 32'(bus.req_ready), 32'd0);
        end
        frame_end();
        #1;
        sb_pop_check(32'(bus.active_mode));
        check("ready_after_simul_apply", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        sb_push("held_request_not_lost", 3);
        $display("txn request mode=3 accepted after stall");
        check("held_req_pending", 32'(bus.req_ready), 32'd0);
        frame_end();
        #1;
        sb_pop_check(32'(bus.active_mode));
        check("held_req_frames", 32'(bus.frames_left), 32'd3);

        // ---- asynchronous reset mid-frame, mid-countdown, with a pending request ----
        request(0);
        px(1'b1, 300, 200);
        #1;
        check("pre_reset_ui", 32'(bus.ui_en), 32'd1);
        check("pre_reset_pending", 32'(bus.req_ready), 32'd0);
        d0 = done_cnt;
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_mode", 32'(bus.active_mode), 32'd0);
        check("async_rst_ready", 32'(bus.req_ready), 32'd1);
        check("async_rst_frames", 32'(bus.frames_left), 32'd0);
        check("async_rst_ui", 32'(bus.ui_en), 32'd0);
        sb_q.delete();
        $display("txn reset asserted mid-frame");
        tick();
        tick();
        reset = 1'b0;
        frame_end();
        #1;
        check("pending_discarded", 32'(bus.active_mode), 32'd0);
        tick();
        check("rst_no_done", 32'(done_cnt), 32'(d0));
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/display_mode_scheduler.md
# display_mode_scheduler

Frame-synchronous controller that decides which source the RGB selector shows. It accepts display-mode requests from the game FSM through a valid/ready handshake and holds each request until the last active pixel of the current frame, so a mode change never tears mid-frame. It generates the per-pixel `ui_en` that drives the selector's UI-priority input, and runs a frame-counted countdown overlay that returns to live view by itself. The block sits between the game FSM and the RGB selector, in the pixel-clock domain of the VGA timing generator.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `BANNER_H`, 48: height in lines of the top UI banner.
- `CNT_FRAMES`, 180: countdown length in frames (3 s at 60 Hz); range 1..255.
- `BOX_X0`/`BOX_X1`/`BOX_Y0`/`BOX_Y1`, 240/400/176/304: countdown box, half-open `[X0,X1)` × `[Y0,Y1)`.

- `clk`  in  1  pixel clock; one pixel per cycle while `DE`=1.
- `reset`  in  1  asynchronous, active-high reset.
- `DE`  in  1  data enable from the VGA timing generator.
- `x_pixel`  in  10  current x coordinate.
- `y_pixel`  in  10  current y coordinate.
- `req_valid`  in  1  mode request valid.
- `req_mode`  in  2  requested mode: 0 LIVE, 1 FULL, 2 BANNER, 3 COUNT.
- `req_ready`  out  1  high when the scheduler can accept a request.
- `ui_en`  out  1  UI-priority enable to the RGB selector.
- `active_mode`  out  2  mode currently on screen.
- `frames_left`  out  8  countdown frames remaining; 0 outside COUNT.
- `countdown_done`  out  1  one-cycle pulse when COUNT expires naturally.

## Operation
- `frame_end` = `DE && x_pixel==H_ACTIVE-1 && y_pixel==V_ACTIVE-1`. It is combinational and high for exactly one cycle per frame.
- Pending register: `pend_valid` and `pend_mode`. `req_ready = !pend_valid`.
- A handshake occurs when `req_valid && req_ready`; it sets `pend_valid=1` and `pend_mode=req_mode`.
- While `pend_valid`=1, further requests stall. There is no overwrite.
- Mode FSM states are LIVE, FULL, BANNER and COUNT. State changes happen only on `frame_end`:
  - If `pend_valid`:
    - `active_mode <= pend_mode` and `pend_valid <= 0`.
    - Entering COUNT loads `frames_left <= CNT_FRAMES`.
    - Any other target loads `frames_left <= 0`.
    - A pending request overrides a running countdown. No `countdown_done` is issued.
    - Requesting COUNT while already in COUNT restarts it.
  - Else if in COUNT with `frames_left`>1: `frames_left <= frames_left-1`.
  - Else if in COUNT with `frames_left`==1: go to LIVE, set `frames_left <= 0`, and pulse `countdown_done` in the next cycle.
  - Otherwise: hold.
- If a handshake and `frame_end` occur in the same cycle, the request is not applied at this `frame_end`. It becomes pending and applies at the next `frame_end`.
- `ui_en` is combinational from the registered `active_mode` and the current coordinates, and is always gated by `DE`:
  - LIVE: 0 (the selector shows split dice/filter view).
  - FULL: `DE`.
  - BANNER: `DE && y_pixel<BANNER_H`.
  - COUNT: `DE && x_pixel in [BOX_X0,BOX_X1) && y_pixel in [BOX_Y0,BOX_Y1)`.
- `frames_left` arithmetic is 8-bit unsigned. It never decrements below 1 inside COUNT, so there is no wrap.

## Timing
- Reset values (asynchronous): `active_mode`=LIVE, `pend_valid`=0, `req_ready`=1, `frames_left`=0, `countdown_done`=0, `ui_en`=0.
- `req_ready` falls in the cycle after the handshake.
- `req_ready` rises in the cycle after the `frame_end` that consumes the pending request.
- A new `active_mode` is visible from the cycle after `frame_end`. This is before pixel (0,0) of the next frame, because the blanking interval lies between.
- `ui_en` has zero latency relative to `x_pixel`/`y_pixel`/`DE`.
- `countdown_done` is high for exactly one cycle, the cycle after the expiring `frame_end`.
- Reset mid-frame or mid-countdown discards the pending request and the countdown. No `countdown_done` is issued.
- Coordinates are not checked; the block relies on the timing generator for in-range `x_pixel`/`y_pixel`.

## Test plan
- **Reset:** assert `reset` mid-frame with `pend_valid`=1 in COUNT → `active_mode`=0, `req_ready`=1, `frames_left`=0 and `ui_en`=0 immediately. No `countdown_done` pulse.
- **Frame-aligned switch:** request mode 1 at pixel (100,200).
  - `active_mode` stays 0 through pixel (639,479).
  - `active_mode` becomes 1 in the next cycle.
  - `ui_en`=`DE` for the whole next frame.
  - `req_ready` is low from the cycle after the handshake until the cycle after `frame_end`.
- **BANNER / COUNT windows:**
  - BANNER: `ui_en`=1 at (0,47) and 0 at (0,48).
  - COUNT: `ui_en`=1 at (240,176) and (399,303); `ui_en`=0 at (400,176) and (239,200).
  - Both modes: `ui_en`=0 whenever `DE`=0.
- **Countdown expiry:** with `CNT_FRAMES`=3, request COUNT.
  - `frames_left` reads 3, 2, 1 across three frames.
  - At the 3rd `frame_end` after entry, `active_mode`=0 and `frames_left`=0.
  - `countdown_done` is high for exactly 1 cycle.
- **Override and simultaneity:**
  - In COUNT with `frames_left`=2, request BANNER → at the next `frame_end`, `active_mode`=2 with no `countdown_done`.
  - A request handshaked exactly in the `frame_end` cycle applies one frame later.
  - A second `req_valid` while pending is held off (`req_ready`=0) and is not lost.
